// File: rtl/ldtu_dec_pkg.sv
// Shared constants, word-type enum and field layout for the LiTE-DTU stream decoder.
package ldtu_dec_pkg;
    localparam int Nbits_12 = 12;
    localparam int Nbits_32 = 32;
    localparam int NSampBsl = 5;
    localparam int CntBits  = 8;
    localparam int FLD_W    = Nbits_12 + 1;
    localparam int NFLD     = 5;

    localparam logic [1:0]          HDR_BSL   = 2'b01;
    localparam logic [3:0]          HDR_BSLP  = 4'b1010;
    localparam logic [5:0]          HDR_SIG2  = 6'b001010;
    localparam logic [5:0]          HDR_SIG1  = 6'b001011;
    localparam logic [3:0]          HDR_TRL   = 4'b1101;
    localparam logic [Nbits_32-1:0] IDLE_WORD = 32'hEAAAAAAA;

    typedef enum logic [2:0] {
        W_IDLE, W_BSL, W_BSLP, W_SIG2, W_SIG1, W_TRL, W_ILL
    } wtype_e;

    // Field 0 is the oldest sample, i.e. the first one presented downstream.
    typedef logic [NFLD-1:0][FLD_W-1:0] fields_t;
endpackage

// File: rtl/ldtu_word_classify.sv
// Combinational header decode: word type, sample count and {gain,data} fields.
module ldtu_word_classify
    import ldtu_dec_pkg::*;
(
    input  logic [Nbits_32-1:0] i_word,
    output wtype_e              o_type,
    output logic [2:0]          o_nsamp,
    output fields_t             o_fields,
    output logic                o_illegal
);
    always_comb begin
        o_type   = W_ILL;
        o_nsamp  = 3'd0;
        o_fields = '0;
        if (i_word == IDLE_WORD) begin
            o_type = W_IDLE;
        end else if (i_word[31:30] == HDR_BSL) begin
            o_type  = W_BSL;
            o_nsamp = 3'(NSampBsl);
            for (int i = 0; i < NSampBsl; i++)
                o_fields[i] = {7'd0, i_word[29-6*i -: 6]};
        end else if (i_word[31:28] == HDR_BSLP) begin
            // n outside 1..4 leaves the type illegal
            if (i_word[27:24] >= 4'd1 && i_word[27:24] <= 4'd4) begin
                o_type  = W_BSLP;
                o_nsamp = i_word[26:24];
                for (int i = 0; i < 4; i++)
                    if (3'(i) < i_word[26:24])
                        o_fields[i] = {7'd0, i_word[23-6*i -: 6]};
            end
        end else if (i_word[31:26] == HDR_SIG2) begin
            o_type      = W_SIG2;
            o_nsamp     = 3'd2;
            o_fields[0] = i_word[25:13];
            o_fields[1] = i_word[12:0];
        end else if (i_word[31:26] == HDR_SIG1) begin
            o_type      = W_SIG1;
            o_nsamp     = 3'd1;
            o_fields[0] = i_word[12:0];
        end else if (i_word[31:28] == HDR_TRL) begin
            o_type = W_TRL;
        end
        o_illegal = (o_type == W_ILL);
    end
endmodule

// File: rtl/ldtu_stream_decoder.sv
// Unpacks the DTU word stream into one tagged 12-bit sample per cycle and checks frame trailers.
module ldtu_stream_decoder
    import ldtu_dec_pkg::*;
(
    input  logic                CLK,
    input  logic                RST_N,
    input  logic [Nbits_32-1:0] word_in,
    input  logic                word_valid,
    output logic                word_ready,
    input  logic                sample_ready,
    output logic                sample_valid,
    output logic [Nbits_12-1:0] sample_data,
    output logic                sample_gain,
    output logic                sample_bsl,
    output logic                frame_done,
    output logic [15:0]         frame_cnt,
    output logic                err_header,
    output logic                err_frame
);
    wtype_e              w_type;
    logic [2:0]          w_nsamp;
    fields_t             w_fields;
    logic                w_illegal;

    logic [2:0]          r_rem;
    fields_t             r_buf;
    logic                r_bsl;
    logic [CntBits-1:0]  r_scnt;
    logic [15:0]         r_fcnt;
    logic                r_fd, r_ef, r_eh;

    logic                w_valid, w_ready, w_xfer, w_acc, w_load, w_trl;
    logic [CntBits-1:0]  w_scnt_nxt;

    ldtu_word_classify u_cls (
        .i_word    (word_in),
        .o_type    (w_type),
        .o_nsamp   (w_nsamp),
        .o_fields  (w_fields),
        .o_illegal (w_illegal)
    );

    assign w_valid    = (r_rem != 3'd0);
    assign w_ready    = (r_rem == 3'd0) | ((r_rem == 3'd1) & sample_ready);
    assign w_xfer     = w_valid & sample_ready;
    assign w_acc      = word_valid & w_ready;
    assign w_load     = w_acc & (w_type inside {W_BSL, W_BSLP, W_SIG2, W_SIG1});
    assign w_trl      = w_acc & (w_type == W_TRL);
    // A sample leaving on the trailer edge still belongs to the closing frame.
    assign w_scnt_nxt = r_scnt + CntBits'(w_xfer);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_rem  <= 3'd0;
            r_buf  <= '0;
            r_bsl  <= 1'b0;
            r_scnt <= '0;
            r_fcnt <= 16'd0;
            r_fd   <= 1'b0;
            r_ef   <= 1'b0;
            r_eh   <= 1'b0;
        end else begin
            r_fd <= w_trl;
            r_ef <= w_trl & (word_in[27:20] != w_scnt_nxt);
            r_eh <= w_acc & w_illegal;
            if (w_load) begin
                r_buf <= w_fields;
                r_rem <= w_nsamp;
                r_bsl <= (w_type == W_BSL) | (w_type == W_BSLP);
            end else if (w_xfer) begin
                r_buf <= {FLD_W'(0), r_buf[NFLD-1:1]};
                r_rem <= r_rem - 3'd1;
            end
            if (w_trl) begin
                r_scnt <= '0;
                r_fcnt <= r_fcnt + 16'd1;
            end else begin
                r_scnt <= w_scnt_nxt;
            end
        end
    end

    assign word_ready   = w_ready;
    assign sample_valid = w_valid;
    assign sample_data  = r_buf[0][Nbits_12-1:0];
    assign sample_gain  = r_buf[0][Nbits_12];
    assign sample_bsl   = r_bsl & w_valid;
    assign frame_done   = r_fd;
    assign frame_cnt    = r_fcnt;
    assign err_header   = r_eh;
    assign err_frame    = r_ef;
endmodule

// File: tb/tb_ldtu_stream_decoder.sv
// Directed plus randomized check of the decoder against a queue-based sample model.
module tb_ldtu_stream_decoder;
    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic [31:0] word_in = '0;
    logic        word_valid = 1'b0;
    logic        word_ready;
    logic        sample_ready = 1'b0;
    logic        sample_valid;
    logic [11:0] sample_data;
    logic        sample_gain;
    logic        sample_bsl;
    logic        frame_done;
    logic [15:0] frame_cnt;
    logic        err_header;
    logic        err_frame;

    ldtu_stream_decoder dut (
        .CLK(CLK), .RST_N(RST_N), .word_in(word_in), .word_valid(word_valid),
        .word_ready(word_ready), .sample_ready(sample_ready), .sample_valid(sample_valid),
        .sample_data(sample_data), .sample_gain(sample_gain), .sample_bsl(sample_bsl),
        .frame_done(frame_done), .frame_cnt(frame_cnt), .err_header(err_header),
        .err_frame(err_frame)
    );

    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_err = 0;

    // Model: pending samples as {bsl, gain, data}, plus counters and expected pulses.
    logic [13:0] mq[$];
    int          mscnt = 0;
    int          mfcnt = 0;
    bit          efd = 0, eef = 0, eeh = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_word(input logic [31:0] w);
        int n;
        if (w == 32'hEAAAAAAA) begin
        end else if (w[31:30] == 2'b01) begin
            for (int i = 0; i < 5; i++)
                mq.push_back({2'b10, 12'((w >> (24 - 6*i)) & 32'h3F)});
        end else if (w[31:28] == 4'hA) begin
            n = int'(w[27:24]);
            if (n >= 1 && n <= 4) begin
                for (int i = 0; i < n; i++)
                    mq.push_back({2'b10, 12'((w >> (18 - 6*i)) & 32'h3F)});
            end else eeh = 1;
        end else if (w[31:26] == 6'b001010) begin
            mq.push_back({1'b0, w[25:13]});
            mq.push_back({1'b0, w[12:0]});
        end else if (w[31:26] == 6'b001011) begin
            mq.push_back({1'b0, w[12:0]});
        end else if (w[31:28] == 4'hD) begin
            efd   = 1;
            eef   = (int'(w[27:20]) != mscnt);
            mfcnt = (mfcnt + 1) % 65536;
            mscnt = 0;
        end else eeh = 1;
    endtask

    // One cycle: drive at the falling edge, check, advance model, cross the rising edge.
    task automatic step(input bit wv, input logic [31:0] w, input bit sr, output bit acc);
        bit ev, er;
        logic [13:0] hd;
        word_valid = wv; word_in = w; sample_ready = sr;
        #1;
        ev = (mq.size() > 0);
        er = (mq.size() == 0) || (mq.size() == 1 && sr);
        chk("sample_valid", 32'(sample_valid), 32'(ev));
        chk("word_ready", 32'(word_ready), 32'(er));
        if (ev) begin
            hd = mq[0];
            chk("sample_data", 32'(sample_data), 32'(hd[11:0]));
            chk("sample_gain", 32'(sample_gain), 32'(hd[12]));
            chk("sample_bsl", 32'(sample_bsl), 32'(hd[13]));
        end
        chk("frame_done", 32'(frame_done), 32'(efd));
        chk("err_frame", 32'(err_frame), 32'(eef));
        chk("err_header", 32'(err_header), 32'(eeh));
        chk("frame_cnt", 32'(frame_cnt), 32'(mfcnt));
        acc = wv && er;
        efd = 0; eef = 0; eeh = 0;
        if (ev && sr) begin
            void'(mq.pop_front());
            mscnt = (mscnt + 1) % 256;
        end
        if (acc) model_word(w);
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic send(input logic [31:0] w);
        bit a = 0;
        int k = 0;
        while (!a && k < 60) begin
            step(1'b1, w, 1'b1, a);
            k++;
        end
        if (!a) chk("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic idle_cycles(input int n, input bit sr);
        bit a;
        for (int i = 0; i < n; i++) step(1'b0, 32'h0, sr, a);
    endtask

    function automatic logic [31:0] rand_word();
        logic [31:0] r;
        r = $urandom;
        case ($urandom_range(0, 7))
            0: return {2'b01, r[29:0]};
            1: return {4'hA, 4'($urandom_range(0, 6)), r[23:0]};
            2: return {6'b001010, r[25:0]};
            3: return {6'b001011, r[25:0]};
            4: return {4'hD, 8'(mscnt + mq.size()), r[19:0]};
            5: return {4'hD, r[27:0]};
            6: return 32'hEAAAAAAA;
            default: return r;
        endcase
    endfunction

    logic [31:0] w_bsl, w_pair, w_trl7, w_trl6, w_bad1, w_bad2;
    bit a;

    initial begin
        w_bsl  = 32'h41083105;
        w_pair = {6'b001010, 13'h1ABC, 13'h0123};
        w_trl7 = {4'hD, 8'd7, 20'h12345};
        w_trl6 = {4'hD, 8'd6, 20'h0};
        w_bad1 = 32'hF0000000;
        w_bad2 = {4'hA, 4'h0, 24'hFFFFFF};

        #3;
        chk("rst_valid", 32'(sample_valid), 32'd0);
        chk("rst_wready", 32'(word_ready), 32'd1);
        chk("rst_fcnt", 32'(frame_cnt), 32'd0);
        chk("rst_data", 32'(sample_data), 32'd0);
        chk("rst_pulses", 32'({frame_done, err_frame, err_header, sample_bsl}), 32'd0);
        @(negedge CLK);
        RST_N = 1'b1;

        // Good frame: baseline + pair, trailer count 7
        send(w_bsl);
        send(w_pair);
        send(w_trl7);
        idle_cycles(3, 1'b1);
        chk("frame1_cnt", 32'(frame_cnt), 32'd1);

        // Same stream with a wrong trailer count
        send(w_bsl);
        send(w_pair);
        send(w_trl6);
        idle_cycles(3, 1'b1);
        chk("frame2_cnt", 32'(frame_cnt), 32'd2);

        // Illegal headers and idle
        send(w_bad1);
        send(w_bad2);
        send(32'hEAAAAAAA);
        idle_cycles(2, 1'b1);

        // Back-pressure mid-word
        send(w_bsl);
        step(1'b0, 32'h0, 1'b1, a);
        idle_cycles(4, 1'b0);
        idle_cycles(6, 1'b1);

        // Reset with three samples still buffered
        send(w_bsl);
        idle_cycles(2, 1'b1);
        chk("pre_rst_pending", 32'(mq.size()), 32'd3);
        RST_N = 1'b0;
        #1;
        chk("midrst_valid", 32'(sample_valid), 32'd0);
        chk("midrst_fcnt", 32'(frame_cnt), 32'd0);
        chk("midrst_wready", 32'(word_ready), 32'd1);
        mq.delete();
        mscnt = 0; mfcnt = 0; efd = 0; eef = 0; eeh = 0;
        @(posedge CLK);
        @(negedge CLK);
        RST_N = 1'b1;
        send(w_pair);
        send({4'hD, 8'd2, 20'h0});
        idle_cycles(3, 1'b1);

        // Randomized traffic with random handshakes
        for (int i = 0; i < 3000; i++)
            step(($urandom_range(0, 3) != 0), rand_word(), ($urandom_range(0, 3) != 0), a);
        idle_cycles(8, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout want finish");
        $fatal(1, "watchdog");
    end
endmodule
